// File: rtl/steer_pkg.sv
// Shared definitions for the steering-enable slice.
// Holds the load-cell sample width, the default rider-weight threshold and
// hysteresis half-band, the default settle-timer length, the timer width,
// and the two-state filter enum used by the load-cell monitor.
package steer_pkg;

  localparam int LD_W = 12;

  localparam logic [LD_W-1:0] MIN_RIDER_WEIGHT = 12'h200;
  localparam logic [LD_W-1:0] HYSTERESIS       = 12'h040;

  // 1.3 s at 50 MHz.
  localparam int TMR_CYCLES = 65_000_000;
  localparam int TMR_W      = 26;

  typedef enum logic {
    EMPTY  = 1'b0,
    PRIMED = 1'b1
  } flt_state_t;

endpackage

// File: rtl/ld_avg4.sv
// One side's 4-tap moving-average filter.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   sample_i   - load-cell sample
//   vld_i      - sample strobe; shifts sample_i in and drops the oldest tap
//   prime_i    - first sample after reset; loads sample_i into every tap
//   avg_o      - (sum of the four taps) >> 2
module ld_avg4 #(
  parameter int LD_W = steer_pkg::LD_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] sample_i,
  input  logic            vld_i,
  input  logic            prime_i,
  output logic [LD_W-1:0] avg_o
);

  import steer_pkg::*;

  logic [LD_W-1:0] taps_q [4];
  logic [LD_W-1:0] taps_d [4];
  logic [LD_W+1:0] acc;

  // Tap registers; all taps clear to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) taps_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) taps_q[i] <= taps_d[i];
    end
  end

  // Priming fills every tap with the first sample so the average starts at
  // the real load instead of ramping up from zero. Otherwise a strobe
  // shifts the new sample in at tap 0; with no strobe the taps hold.
  always_comb begin
    for (int i = 0; i < 4; i++) taps_d[i] = taps_q[i];
    if (prime_i) begin
      for (int i = 0; i < 4; i++) taps_d[i] = sample_i;
    end else if (vld_i) begin
      taps_d[0] = sample_i;
      for (int i = 1; i < 4; i++) taps_d[i] = taps_q[i-1];
    end
  end

  // Two extra accumulator bits hold the four-tap sum without overflow.
  always_comb begin
    acc = '0;
    for (int i = 0; i < 4; i++) acc = acc + {2'b00, taps_q[i]};
  end

  assign avg_o = acc[LD_W+1:2];

endmodule

// File: rtl/ld_cell_monitor.sv
// Load-cell monitor: producer side of the steering-enable interface.
// Filters the left and right load cells, derives the rider-weight flags
// with hysteresis and the balance flags, and owns the settle timer.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   lft_ld, rght_ld - left and right load-cell samples
//   ld_vld          - one-cycle strobe marking a valid sample pair
//   clr_tmr         - synchronous clear of the settle timer
//   sum_gt_min      - filtered sum above the upper hysteresis threshold
//   sum_lt_min      - filtered sum below the lower hysteresis threshold
//   diff_gt_1_4     - |lft - rght| > sum/4
//   diff_gt_15_16   - |lft - rght| > sum*15/16
//   tmr_full        - settle timer has reached TMR_CYCLES-1
//   flt_prmd        - filter has seen at least one sample since reset
module ld_cell_monitor #(
  parameter int                   LD_W             = steer_pkg::LD_W,
  parameter logic [LD_W-1:0]      MIN_RIDER_WEIGHT = steer_pkg::MIN_RIDER_WEIGHT,
  parameter logic [LD_W-1:0]      HYSTERESIS       = steer_pkg::HYSTERESIS,
  parameter int                   TMR_CYCLES       = steer_pkg::TMR_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  input  logic            ld_vld,
  input  logic            clr_tmr,
  output logic            sum_gt_min,
  output logic            sum_lt_min,
  output logic            diff_gt_1_4,
  output logic            diff_gt_15_16,
  output logic            tmr_full,
  output logic            flt_prmd
);

  import steer_pkg::*;

  localparam logic [LD_W:0]    HI_THR  = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};
  localparam logic [LD_W:0]    LO_THR  = {1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS};
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TMR_CYCLES - 1);

  flt_state_t      fltState_q;
  flt_state_t      fltState_d;
  logic            prime;
  logic [LD_W-1:0] lftFlt;
  logic [LD_W-1:0] rghtFlt;
  logic [LD_W:0]   sum;
  logic [LD_W-1:0] diff;
  logic [LD_W:0]   quarter;
  logic [LD_W:0]   ff16;
  logic            sumGt_q;
  logic            sumLt_q;
  logic            diffGt14_q;
  logic            diffGt1516_q;
  logic [TMR_W-1:0] tmrCnt_q;
  logic [TMR_W-1:0] tmrCnt_d;

  // Filter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fltState_q <= EMPTY;
    else     fltState_q <= fltState_d;
  end

  // The first sample primes the filter; after that only reset leaves PRIMED.
  always_comb begin
    fltState_d = fltState_q;
    if (fltState_q == EMPTY && ld_vld) fltState_d = PRIMED;
  end

  // A single prime strobe drives both sides so they always prime together.
  always_comb begin
    flt_prmd = (fltState_q == PRIMED);
    prime    = (fltState_q == EMPTY) && ld_vld;
  end

  ld_avg4 #(.LD_W(LD_W)) uLftAvg (
    .clk      (clk),
    .rst      (rst),
    .sample_i (lft_ld),
    .vld_i    (ld_vld),
    .prime_i  (prime),
    .avg_o    (lftFlt)
  );

  ld_avg4 #(.LD_W(LD_W)) uRghtAvg (
    .clk      (clk),
    .rst      (rst),
    .sample_i (rght_ld),
    .vld_i    (ld_vld),
    .prime_i  (prime),
    .avg_o    (rghtFlt)
  );

  // Sum, absolute difference and the two balance thresholds, all on the
  // filtered values. The 15/16 threshold is sum minus a sixteenth of it.
  always_comb begin
    sum     = {1'b0, lftFlt} + {1'b0, rghtFlt};
    diff    = (lftFlt >= rghtFlt) ? (lftFlt - rghtFlt) : (rghtFlt - lftFlt);
    quarter = sum >> 2;
    ff16    = sum - (sum >> 4);
  end

  // Registered flags. The two weight thresholds sit either side of the
  // nominal weight, so the flags can never be set together and both are
  // clear inside the band. Taps hold between samples, so the flags do too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sumGt_q      <= 1'b0;
      sumLt_q      <= 1'b1;
      diffGt14_q   <= 1'b0;
      diffGt1516_q <= 1'b0;
    end else begin
      sumGt_q      <= (sum > HI_THR);
      sumLt_q      <= (sum < LO_THR);
      diffGt14_q   <= ({1'b0, diff} > quarter);
      diffGt1516_q <= ({1'b0, diff} > ff16);
    end
  end

  assign sum_gt_min    = sumGt_q;
  assign sum_lt_min    = sumLt_q;
  assign diff_gt_1_4   = diffGt14_q;
  assign diff_gt_15_16 = diffGt1516_q;

  // Settle timer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmrCnt_q <= '0;
    else     tmrCnt_q <= tmrCnt_d;
  end

  // Clear wins over counting; the count saturates at its terminal value so
  // tmr_full stays up until the next clear.
  always_comb begin
    tmrCnt_d = tmrCnt_q;
    if (clr_tmr)                tmrCnt_d = '0;
    else if (tmrCnt_q != TMR_MAX) tmrCnt_d = tmrCnt_q + 1'b1;
  end

  assign tmr_full = (tmrCnt_q == TMR_MAX);

endmodule

// File: tb/tb_ld_cell_monitor.sv
// Directed testbench for ld_cell_monitor with a short settle timer.
module tb_ld_cell_monitor;

  logic        clk;
  logic        rst;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        ld_vld;
  logic        clr_tmr;
  logic        sum_gt_min;
  logic        sum_lt_min;
  logic        diff_gt_1_4;
  logic        diff_gt_15_16;
  logic        tmr_full;
  logic        flt_prmd;

  int totalChecks = 0;
  int badChecks   = 0;

  ld_cell_monitor #(
    .LD_W             (12),
    .MIN_RIDER_WEIGHT (12'h200),
    .HYSTERESIS       (12'h040),
    .TMR_CYCLES       (100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lft_ld        (lft_ld),
    .rght_ld       (rght_ld),
    .ld_vld        (ld_vld),
    .clr_tmr       (clr_tmr),
    .sum_gt_min    (sum_gt_min),
    .sum_lt_min    (sum_lt_min),
    .diff_gt_1_4   (diff_gt_1_4),
    .diff_gt_15_16 (diff_gt_15_16),
    .tmr_full      (tmr_full),
    .flt_prmd      (flt_prmd)
  );

  // Free-running 100 MHz bench clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value with its expected value and tallies it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advances one clock and lands just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one sample pair for one cycle; taps update on the edge.
  task automatic applyStimulus(input logic [11:0] l, input logic [11:0] r);
    lft_ld  = l;
    rght_ld = r;
    ld_vld  = 1'b1;
    tick();
    ld_vld  = 1'b0;
  endtask

  // Sends the same pair four times so every tap holds it, then waits for flags.
  task automatic fillTaps(input logic [11:0] l, input logic [11:0] r);
    for (int i = 0; i < 4; i++) applyStimulus(l, r);
    tick();
  endtask

  // Main directed sequence.
  initial begin
    rst     = 1'b1;
    lft_ld  = '0;
    rght_ld = '0;
    ld_vld  = 1'b0;
    clr_tmr = 1'b0;

    repeat (3) tick();
    checkOutput("rst_lt",     {31'b0, sum_lt_min},    32'd1);
    checkOutput("rst_gt",     {31'b0, sum_gt_min},    32'd0);
    checkOutput("rst_d14",    {31'b0, diff_gt_1_4},   32'd0);
    checkOutput("rst_d1516",  {31'b0, diff_gt_15_16}, 32'd0);
    checkOutput("rst_tmr",    {31'b0, tmr_full},      32'd0);
    checkOutput("rst_prmd",   {31'b0, flt_prmd},      32'd0);
    rst = 1'b0;
    tick();

    // Prime with 0x150 per side: sum 0x2A0.
    applyStimulus(12'h150, 12'h150);
    checkOutput("prime_prmd", {31'b0, flt_prmd},   32'd1);
    checkOutput("prime_lat",  {31'b0, sum_gt_min}, 32'd0);
    tick();
    checkOutput("prime_gt",   {31'b0, sum_gt_min},    32'd1);
    checkOutput("prime_lt",   {31'b0, sum_lt_min},    32'd0);
    checkOutput("prime_d14",  {31'b0, diff_gt_1_4},   32'd0);
    checkOutput("prime_d1516",{31'b0, diff_gt_15_16}, 32'd0);

    // Sum 0x200 sits inside the band.
    fillTaps(12'h100, 12'h100);
    checkOutput("band_gt", {31'b0, sum_gt_min}, 32'd0);
    checkOutput("band_lt", {31'b0, sum_lt_min}, 32'd0);

    // Moving average: one 0x180 over 0x100 taps gives 0x120 per side (0x240).
    applyStimulus(12'h180, 12'h180);
    tick();
    checkOutput("avg1_gt", {31'b0, sum_gt_min}, 32'd0);
    // Second 0x180 gives 0x140 per side (0x280).
    applyStimulus(12'h180, 12'h180);
    tick();
    checkOutput("avg2_gt", {31'b0, sum_gt_min}, 32'd1);

    fillTaps(12'h0D0, 12'h0D0);
    checkOutput("low_lt", {31'b0, sum_lt_min}, 32'd1);
    checkOutput("low_gt", {31'b0, sum_gt_min}, 32'd0);

    // Threshold edges: 0x241 above, 0x1C0 inside, 0x1BF below.
    fillTaps(12'h121, 12'h120);
    checkOutput("hi_edge_gt", {31'b0, sum_gt_min}, 32'd1);
    fillTaps(12'h0E0, 12'h0E0);
    checkOutput("lo_edge_lt", {31'b0, sum_lt_min}, 32'd0);
    checkOutput("lo_edge_gt", {31'b0, sum_gt_min}, 32'd0);
    fillTaps(12'h0E0, 12'h0DF);
    checkOutput("below_lt",   {31'b0, sum_lt_min}, 32'd1);

    // Balance flags.
    fillTaps(12'h300, 12'h100);
    checkOutput("bal_d14",   {31'b0, diff_gt_1_4},   32'd1);
    checkOutput("bal_d1516", {31'b0, diff_gt_15_16}, 32'd0);
    fillTaps(12'h3F0, 12'h000);
    checkOutput("side_d14",   {31'b0, diff_gt_1_4},   32'd1);
    checkOutput("side_d1516", {31'b0, diff_gt_15_16}, 32'd1);
    // diff 0x40 equals sum/4 exactly: strict compare keeps the flag low.
    fillTaps(12'h0A0, 12'h060);
    checkOutput("eq_d14", {31'b0, diff_gt_1_4}, 32'd0);
    fillTaps(12'h000, 12'h000);
    checkOutput("zero_d14",   {31'b0, diff_gt_1_4},   32'd0);
    checkOutput("zero_d1516", {31'b0, diff_gt_15_16}, 32'd0);
    checkOutput("zero_lt",    {31'b0, sum_lt_min},    32'd1);

    // Timer cleared in the same cycle as a sample; both must take effect.
    clr_tmr = 1'b1;
    applyStimulus(12'h3FC, 12'h3FC);
    clr_tmr = 1'b0;
    checkOutput("clr_tmr0", {31'b0, tmr_full}, 32'd0);
    tick();
    checkOutput("clr_smp_lt", {31'b0, sum_lt_min}, 32'd0);
    repeat (97) tick();
    checkOutput("tmr_98", {31'b0, tmr_full}, 32'd0);
    tick();
    checkOutput("tmr_99", {31'b0, tmr_full}, 32'd1);
    repeat (5) tick();
    checkOutput("tmr_hold", {31'b0, tmr_full}, 32'd1);

    // Clear drops tmr_full on the same edge, then clear again at count 50.
    clr_tmr = 1'b1;
    tick();
    clr_tmr = 1'b0;
    checkOutput("tmr_fall", {31'b0, tmr_full}, 32'd0);
    repeat (50) tick();
    clr_tmr = 1'b1;
    tick();
    clr_tmr = 1'b0;
    repeat (98) tick();
    checkOutput("tmr_re98", {31'b0, tmr_full}, 32'd0);
    tick();
    checkOutput("tmr_re99", {31'b0, tmr_full}, 32'd1);

    // Mid-stream reset with the filter primed and the timer at 60.
    clr_tmr = 1'b1;
    tick();
    clr_tmr = 1'b0;
    repeat (60) tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_lt",   {31'b0, sum_lt_min},    32'd1);
    checkOutput("mid_gt",   {31'b0, sum_gt_min},    32'd0);
    checkOutput("mid_d14",  {31'b0, diff_gt_1_4},   32'd0);
    checkOutput("mid_prmd", {31'b0, flt_prmd},      32'd0);
    checkOutput("mid_tmr",  {31'b0, tmr_full},      32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Re-prime with 0x200 per side: sum 0x400.
    applyStimulus(12'h200, 12'h200);
    checkOutput("rep_prmd", {31'b0, flt_prmd},   32'd1);
    checkOutput("rep_lat",  {31'b0, sum_gt_min}, 32'd0);
    tick();
    checkOutput("rep_gt",   {31'b0, sum_gt_min}, 32'd1);
    checkOutput("rep_lt",   {31'b0, sum_lt_min}, 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/ld_cell_monitor.md
Name: ld_cell_monitor

Overview:
Producer side of the steering-enable interface. It filters left and right load-cell samples and derives the rider-weight and balance flags with hysteresis: sum_gt_min, sum_lt_min, diff_gt_1_4 and diff_gt_15_16. It also owns the 1.3 s settle timer, which the steering-enable state machine clears via clr_tmr and reads back as tmr_full. It sits between the load-cell sampling front end and the steering-enable state machine.

Parameters:
LD_W, 12, load-cell sample width.
MIN_RIDER_WEIGHT, 12'h200, nominal rider-present threshold on the filtered sum.
HYSTERESIS, 12'h040, half-band around MIN_RIDER_WEIGHT.
TMR_CYCLES, 65_000_000, cycles to tmr_full (1.3 s at 50 MHz); benches override with small values.

Ports:
clk  in  1  50 MHz clock
rst  in  1  asynchronous reset, active-high
lft_ld  in  LD_W  left load-cell sample
rght_ld  in  LD_W  right load-cell sample
ld_vld  in  1  one-cycle strobe; lft_ld and rght_ld are valid this cycle
clr_tmr  in  1  synchronous clear of the settle timer
sum_gt_min  out  1  filtered sum > MIN_RIDER_WEIGHT + HYSTERESIS
sum_lt_min  out  1  filtered sum < MIN_RIDER_WEIGHT - HYSTERESIS
diff_gt_1_4  out  1  |lft - rght| > sum/4
diff_gt_15_16  out  1  |lft - rght| > sum*15/16
tmr_full  out  1  timer has reached TMR_CYCLES-1
flt_prmd  out  1  filter has received at least one sample since reset

Behaviour:
- One clock. Reset is asynchronous and active-high. Port names are clk and rst.
- Reset values:
  - all filter taps 0; flt_prmd 0
  - sum_gt_min 0, sum_lt_min 1, diff_gt_1_4 0, diff_gt_15_16 0
  - timer count 0, so tmr_full 0
- Filter: one 4-tap moving average per side; output = (sum of taps) >> 2, with a 14-bit accumulator.
  - Filter FSM has two states, EMPTY and PRIMED.
  - EMPTY: the first ld_vld loads the sample into all 4 taps (no warm-up ramp), then goes to PRIMED. flt_prmd = 1 in PRIMED.
  - PRIMED: each ld_vld shifts the new sample in and drops the oldest tap.
  - PRIMED exits only on rst.
  - Taps are unchanged when ld_vld = 0.
- Arithmetic on filtered values lf, rf (LD_W bits each):
  - sum = lf + rf, 13 bits unsigned
  - diff = |lf - rf|, 12 bits
  - quarter = sum >> 2
  - ff16 = sum - (sum >> 4), 13 bits
  - all compares are unsigned and strict (>, <)
- Flags are registered.
  - Latency: ld_vld at cycle N updates taps at N+1; flags reflect the new taps at N+2.
  - Flags hold between samples.
- Hysteresis: sum_gt_min and sum_lt_min are never both 1. Inside the band [0x1C0, 0x240] (defaults) both are 0.
- sum = 0 gives diff 0, so both diff flags are 0 (strict compare).
- Timer:
  - 26-bit counter.
  - clr_tmr = 1: count <= 0 next edge. Clear has priority over increment.
  - Otherwise count increments, saturating at TMR_CYCLES-1.
  - tmr_full = (count == TMR_CYCLES-1), decoded from the count register.
  - tmr_full falls on the edge that applies clr_tmr.
  - The timer is independent of ld_vld; simultaneous clr_tmr and ld_vld are both honoured.
- rst mid-operation: all state returns to reset values immediately (asynchronous). The next sample re-primes the filter.

Decomposition:
- Shared package steer_pkg:
  - LD_W
  - MIN_RIDER_WEIGHT and HYSTERESIS defaults
  - TMR_CYCLES default
  - filter state enum flt_state_t {EMPTY, PRIMED}
- Sub-module ld_avg4: one side's 4-tap filter, including the prime-on-first-sample behaviour. Instantiated twice (left, right), driven by a shared prime signal.
- Comparators and timer stay in the top level.

Test Plan:
1. Reset, hold rst 3 cycles -> sum_lt_min = 1, the other three flags 0, tmr_full 0, flt_prmd 0.
2. Single ld_vld with lft = rght = 0x150 -> two cycles later sum = 0x2A0: sum_gt_min = 1, sum_lt_min = 0, both diff flags 0, flt_prmd 1.
3. Then four ld_vld with lft = rght = 0x100 -> filtered sum settles at 0x200: sum_gt_min = 0, sum_lt_min = 0. Then four samples of 0x0D0 each -> sum 0x1A0: sum_lt_min = 1.
4. Steady lft = 0x300, rght = 0x100 -> diff_gt_1_4 = 1, diff_gt_15_16 = 0. Steady lft = 0x3F0, rght = 0x000 -> both diff flags = 1.
5. TMR_CYCLES = 100: pulse clr_tmr -> tmr_full = 1 exactly 99 cycles after clr deasserts, and holds. clr_tmr at count 50 -> tmr_full does not assert until 99 cycles after that clear.
6. Assert rst mid-stream (filter primed, timer at 60) -> outputs take reset values immediately. The next ld_vld with lft = rght = 0x200 re-primes the filter; sum_gt_min = 1 at N+2.
